glitch_pulser_seq: RTL and testbench
====================================

// Module: glitch_pulser_seq
// PURPOSE
//  Parametrised successor to the fixed 8/16-bit pulse-train generator in the glitcher datapath.
//  Emits a train of N pulses after a programmable trigger delay.
//  Adds abort, completion strobe, pulse index, output polarity and optional per-pulse width sweep.
//  Sits between the trigger/arm logic and the glitch output driver.
//  All config is latched on start, so it may change while a train runs.
// PARAMETERS
//  DELAY_BITS    16  width of delay_i (trigger-to-first-pulse delay counter)
//  WIDTH_BITS     8  width of width_i / width_step_i
//  COUNT_BITS     8  width of num_pulses_i / pulse_idx_o
//  SPACING_BITS  16  width of spacing_i
//  ACTIVE_HIGH    1  1: pulse level is 1, idle level is 0; 0: inverted
// PORTS
//  clk           in   1             clock
//  rst           in   1             reset; synchronous, active-high
//  start_i       in   1             start a train; sampled only while ready_o=1
//  abort_i       in   1             cancel any running train
//  delay_i       in   DELAY_BITS    cycles from start acceptance to first pulse
//  width_i       in   WIDTH_BITS    pulse high time in cycles (0 treated as 1)
//  num_pulses_i  in   COUNT_BITS    pulses per train (0 = empty train)
//  spacing_i     in   SPACING_BITS  idle cycles between pulses (0 treated as 1)
//  width_step_i  in   WIDTH_BITS    per-pulse width increment (used only with sweep macro)
//  pulse_o       out  1             glitch pulse, registered
//  ready_o       out  1             1 = IDLE, start_i will be accepted
//  done_o        out  1             1-cycle strobe on natural train completion
//  pulse_idx_o   out  COUNT_BITS    0-based index of current/last pulse
// BEHAVIOUR
//  Reset values: pulse_o=~ACTIVE_HIGH, ready_o=1, done_o=0, pulse_idx_o=0, state=IDLE.
//  FSM states: IDLE, DELAY, ACTIVE, SPACE; any illegal encoding -> IDLE.
//  IDLE->DELAY when start_i=1, abort_i=0 and num_pulses_i!=0.
//   - latch all *_i config; ready_o=0 next cycle
//  Empty train: start_i with num_pulses_i=0 -> stays IDLE, done_o=1 next cycle, no pulse.
//  DELAY: count delay_i cycles, then ACTIVE.
//   - start accepted at edge E -> pulse_o active from edge E+1+delay_i
//   - delay_i=0 -> pulse_o active from edge E+1
//  ACTIVE: pulse_o active for exactly max(width,1) cycles.
//   - then SPACE if pulses remain; else IDLE with done_o=1, ready_o=1, pulse_o idle in the same cycle
//  SPACE: pulse_o idle for exactly max(spacing_i,1) cycles, then ACTIVE; pulse_idx_o increments on that entry.
//  Counters are full-width and never wrap inside a train; max values are legal:
//   - delay=2^DELAY_BITS-1
//   - count=2^COUNT_BITS-1
//  abort_i=1 in a non-IDLE state: next cycle state=IDLE, pulse_o idle, ready_o=1, done_o stays 0.
//  abort_i has priority over start_i in the same cycle; nothing starts.
//  start_i while ready_o=0 is ignored; no queuing.
//  rst mid-train: immediate return to reset values at the next edge.
//  pulse_idx_o holds its last value in IDLE; cleared to 0 on start acceptance.
// CONFIGURATION
//  GLITCH_PULSER_SWEEP_EN defined:
//   - width of pulse k = width_i + k*width_step_i, saturating at 2^WIDTH_BITS-1
//   - accumulator is updated on each ACTIVE->SPACE transition
//  GLITCH_PULSER_SWEEP_EN undefined:
//   - width_step_i is ignored; all pulses use the latched width_i
//   - no accumulator logic is synthesised
// TESTING
//  1. delay=0, width=3, n=1 -> pulse_o active cycles E+1..E+3; done_o at E+4; ready_o=1 at E+4.
//  2. delay=5, width=2, n=3, spacing=4 -> pattern 5 idle, 2 on, 4 off, 2 on, 4 off, 2 on; pulse_idx_o = 0,1,2.
//  3. width=0, spacing=0, n=2 -> 1 on, 1 off, 1 on; n=0 -> done_o strobe, no pulse.
//  4. abort_i during 2nd pulse of n=4 -> pulse_o idle next cycle, ready_o=1, no done_o; start in the same cycle ignored.
//  5. ACTIVE_HIGH=0: reset pulse_o=1, pulse drives 0; start while busy and rst mid-DELAY -> no pulse, reset values.
//  6. SWEEP_EN: width=250, step=3, n=4 -> widths 250,253,255,255; undefined -> 250 x4.

Source files
------------

// File: rtl/glitch_pulser_seq.sv
// Pulse-train generator: N pulses after a programmable delay, with abort, done strobe and polarity.
// Optional per-pulse width sweep enabled by defining GLITCH_PULSER_SWEEP_EN.
module glitch_pulser_seq #(
    parameter int DELAY_BITS   = 16,
    parameter int WIDTH_BITS   = 8,
    parameter int COUNT_BITS   = 8,
    parameter int SPACING_BITS = 16,
    parameter int ACTIVE_HIGH  = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [DELAY_BITS-1:0]   delay_i,
    input  logic [WIDTH_BITS-1:0]   width_i,
    input  logic [COUNT_BITS-1:0]   num_pulses_i,
    input  logic [SPACING_BITS-1:0] spacing_i,
    input  logic [WIDTH_BITS-1:0]   width_step_i,
    output logic                    pulse_o,
    output logic                    ready_o,
    output logic                    done_o,
    output logic [COUNT_BITS-1:0]   pulse_idx_o
);

    // state  | meaning
    // IDLE   | waiting for start, ready_o=1
    // DELAY  | counting trigger-to-first-pulse delay
    // ACTIVE | pulse asserted, counting width
    // SPACE  | pulse idle between pulses, counting spacing
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DELAY  = 2'd1,
        S_ACTIVE = 2'd2,
        S_SPACE  = 2'd3
    } state_t;

    localparam int CNT_BITS_A = (DELAY_BITS > SPACING_BITS) ? DELAY_BITS : SPACING_BITS;
    localparam int CNT_BITS   = (CNT_BITS_A > WIDTH_BITS) ? CNT_BITS_A : WIDTH_BITS;
    localparam logic P_ON     = (ACTIVE_HIGH != 0);
    localparam logic P_OFF    = (ACTIVE_HIGH == 0);

    state_t                  r_state, w_state;
    logic [CNT_BITS-1:0]     r_cnt, w_cnt;
    logic [WIDTH_BITS-1:0]   r_width, w_width;
    logic [SPACING_BITS-1:0] r_spacing, w_spacing;
    logic [COUNT_BITS-1:0]   r_num, w_num;
    logic [COUNT_BITS-1:0]   r_idx, w_idx;
    logic                    r_pulse, w_pulse;
    logic                    r_done, w_done;

    logic [WIDTH_BITS-1:0]   w_width_eff;
    logic [SPACING_BITS-1:0] w_spacing_eff;
    logic [CNT_BITS-1:0]     w_width_load;
    logic [CNT_BITS-1:0]     w_spacing_load;
    logic                    w_last;

    // Zero width/spacing behave as one cycle; counters are loaded with (length - 1).
    assign w_width_eff    = (r_width == '0) ? WIDTH_BITS'(1) : r_width;
    assign w_spacing_eff  = (r_spacing == '0) ? SPACING_BITS'(1) : r_spacing;
    assign w_width_load   = CNT_BITS'(w_width_eff - WIDTH_BITS'(1));
    assign w_spacing_load = CNT_BITS'(w_spacing_eff - SPACING_BITS'(1));
    assign w_last         = (r_idx == (r_num - COUNT_BITS'(1)));

`ifdef GLITCH_PULSER_SWEEP_EN
    logic [WIDTH_BITS-1:0] r_step, w_step;
    logic [WIDTH_BITS:0]   w_width_sum;
    logic [WIDTH_BITS-1:0] w_width_sat;

    assign w_width_sum = {1'b0, r_width} + {1'b0, r_step};
    assign w_width_sat = w_width_sum[WIDTH_BITS] ? '1 : w_width_sum[WIDTH_BITS-1:0];
`else
    logic w_unused_step;
    assign w_unused_step = ^width_step_i;
`endif

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_width   = r_width;
        w_spacing = r_spacing;
        w_num     = r_num;
        w_idx     = r_idx;
        w_pulse   = P_OFF;
        w_done    = 1'b0;
`ifdef GLITCH_PULSER_SWEEP_EN
        w_step    = r_step;
`endif
        if (r_state != S_IDLE && abort_i) begin
            w_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i && !abort_i) begin
                        if (num_pulses_i != '0) begin
                            w_state   = S_DELAY;
                            w_cnt     = CNT_BITS'(delay_i);
                            w_width   = width_i;
                            w_spacing = spacing_i;
                            w_num     = num_pulses_i;
                            w_idx     = '0;
`ifdef GLITCH_PULSER_SWEEP_EN
                            w_step    = width_step_i;
`endif
                        end else begin
                            w_done = 1'b1;
                        end
                    end
                end
                S_DELAY: begin
                    if (r_cnt == '0) begin
                        w_state = S_ACTIVE;
                        w_pulse = P_ON;
                        w_cnt   = w_width_load;
                    end else begin
                        w_cnt = r_cnt - CNT_BITS'(1);
                    end
                end
                S_ACTIVE: begin
                    if (r_cnt == '0) begin
                        if (w_last) begin
                            w_state = S_IDLE;
                            w_done  = 1'b1;
                        end else begin
                            w_state = S_SPACE;
                            w_cnt   = w_spacing_load;
`ifdef GLITCH_PULSER_SWEEP_EN
                            w_width = w_width_sat;
`endif
                        end
                    end else begin
                        w_cnt   = r_cnt - CNT_BITS'(1);
                        w_pulse = P_ON;
                    end
                end
                S_SPACE: begin
                    if (r_cnt == '0) begin
                        w_state = S_ACTIVE;
                        w_pulse = P_ON;
                        w_cnt   = w_width_load;
                        w_idx   = r_idx + COUNT_BITS'(1);
                    end else begin
                        w_cnt = r_cnt - CNT_BITS'(1);
                    end
                end
                default: begin
                    w_state = S_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_width   <= '0;
            r_spacing <= '0;
            r_num     <= '0;
            r_idx     <= '0;
            r_pulse   <= P_OFF;
            r_done    <= 1'b0;
`ifdef GLITCH_PULSER_SWEEP_EN
            r_step    <= '0;
`endif
        end else begin
            r_state   <= w_state;
            r_cnt     <= w_cnt;
            r_width   <= w_width;
            r_spacing <= w_spacing;
            r_num     <= w_num;
            r_idx     <= w_idx;
            r_pulse   <= w_pulse;
            r_done    <= w_done;
`ifdef GLITCH_PULSER_SWEEP_EN
            r_step    <= w_step;
`endif
        end
    end

    assign pulse_o     = r_pulse;
    assign ready_o     = (r_state == S_IDLE);
    assign done_o      = r_done;
    assign pulse_idx_o = r_idx;

endmodule

// File: tb/tb_glitch_pulser_seq.sv
// Self-checking bench for glitch_pulser_seq: schedule-based model plus directed literal checks.
// Drives an active-high and an active-low instance with the same stimulus.
module tb_glitch_pulser_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i, abort_i;
    logic [15:0] delay_i;
    logic [7:0]  width_i;
    logic [7:0]  num_pulses_i;
    logic [15:0] spacing_i;
    logic [7:0]  width_step_i;

    logic        pulse_o, ready_o, done_o;
    logic [7:0]  pulse_idx_o;
    logic        pulse_n, ready_n, done_n;
    logic [7:0]  idx_n;

    always #5 clk = ~clk;

    glitch_pulser_seq #(.ACTIVE_HIGH(1)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
        .delay_i(delay_i), .width_i(width_i), .num_pulses_i(num_pulses_i),
        .spacing_i(spacing_i), .width_step_i(width_step_i),
        .pulse_o(pulse_o), .ready_o(ready_o), .done_o(done_o), .pulse_idx_o(pulse_idx_o)
    );

    glitch_pulser_seq #(.ACTIVE_HIGH(0)) dut_n (
        .clk(clk), .rst(rst), .start_i(start_i), .abort_i(abort_i),
        .delay_i(delay_i), .width_i(width_i), .num_pulses_i(num_pulses_i),
        .spacing_i(spacing_i), .width_step_i(width_step_i),
        .pulse_o(pulse_n), .ready_o(ready_n), .done_o(done_n), .pulse_idx_o(idx_n)
    );

    int n_checks = 0;
    int n_fail   = 0;
    logic chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: on acceptance the whole train is expanded into a per-cycle schedule of outputs.
    typedef struct packed {
        logic       pulse;
        logic       ready;
        logic       done;
        logic [7:0] idx;
    } ent_t;

    ent_t       q[$];
    ent_t       m_e;
    logic       m_pulse = 1'b0;
    logic       m_ready = 1'b1;
    logic       m_done  = 1'b0;
    logic [7:0] m_idx   = 8'd0;

    function automatic void build_schedule(input int d, input int w, input int n,
                                           input int s, input int st);
        int wk;
        int se;
        se = (s == 0) ? 1 : s;
        for (int i = 0; i <= d; i++) q.push_back('{1'b0, 1'b0, 1'b0, 8'd0});
        for (int k = 0; k < n; k++) begin
`ifdef GLITCH_PULSER_SWEEP_EN
            wk = w + k * st;
            if (wk > 255) wk = 255;
`else
            wk = w + 0 * st;
`endif
            if (wk == 0) wk = 1;
            for (int j = 0; j < wk; j++) q.push_back('{1'b1, 1'b0, 1'b0, 8'(k)});
            if (k < n - 1)
                for (int j = 0; j < se; j++) q.push_back('{1'b0, 1'b0, 1'b0, 8'(k)});
        end
        q.push_back('{1'b0, 1'b1, 1'b1, 8'(n - 1)});
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q.delete();
            m_pulse = 1'b0; m_ready = 1'b1; m_done = 1'b0; m_idx = 8'd0;
        end else if (q.size() != 0) begin
            if (abort_i) begin
                q.delete();
                m_pulse = 1'b0; m_ready = 1'b1; m_done = 1'b0;
            end else begin
                m_e = q.pop_front();
                m_pulse = m_e.pulse; m_ready = m_e.ready; m_done = m_e.done; m_idx = m_e.idx;
            end
        end else begin
            m_pulse = 1'b0; m_ready = 1'b1; m_done = 1'b0;
            if (start_i && !abort_i) begin
                if (num_pulses_i == 8'd0) begin
                    m_done = 1'b1;
                end else begin
                    build_schedule(int'(delay_i), int'(width_i), int'(num_pulses_i),
                                   int'(spacing_i), int'(width_step_i));
                    m_e = q.pop_front();
                    m_pulse = m_e.pulse; m_ready = m_e.ready; m_done = m_e.done; m_idx = m_e.idx;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("pulse",   {31'd0, pulse_o}, {31'd0, m_pulse});
            check("pulse_n", {31'd0, pulse_n}, {31'd0, ~m_pulse});
            check("ready",   {31'd0, ready_o}, {31'd0, m_ready});
            check("done",    {31'd0, done_o},  {31'd0, m_done});
            check("idx",     {24'd0, pulse_idx_o}, {24'd0, m_idx});
            check("ready_n", {31'd0, ready_n}, {31'd0, m_ready});
            check("done_n",  {31'd0, done_n},  {31'd0, m_done});
            check("idx_n",   {24'd0, idx_n},   {24'd0, m_idx});
        end
    end

    // Returns at the negedge right after the acceptance edge.
    task automatic do_start(input int d, input int w, input int n, input int s, input int st);
        @(negedge clk);
        delay_i = 16'(d); width_i = 8'(w); num_pulses_i = 8'(n);
        spacing_i = 16'(s); width_step_i = 8'(st);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    logic [31:0] cap;
    logic [7:0]  idx_a, idx_b;
    int          cnt_on, cnt_done, run, npulse, wd[8];
    logic        seen, prev;

    initial begin
        rst = 1'b1; start_i = 1'b0; abort_i = 1'b0;
        delay_i = '0; width_i = '0; num_pulses_i = '0; spacing_i = '0; width_step_i = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_pulse",   {31'd0, pulse_o}, 32'd0);
        check("rst_pulse_n", {31'd0, pulse_n}, 32'd1);
        check("rst_ready",   {31'd0, ready_o}, 32'd1);
        check("rst_done",    {31'd0, done_o},  32'd0);
        check("rst_idx",     {24'd0, pulse_idx_o}, 32'd0);
        rst = 1'b0;

        // single pulse, no delay
        do_start(0, 3, 1, 0, 0);
        cap = '0;
        for (int i = 0; i < 4; i++) begin @(negedge clk); cap = {cap[30:0], pulse_o}; end
        check("t1_pattern", cap, 32'b1110);
        check("t1_done",  {31'd0, done_o},  32'd1);
        check("t1_ready", {31'd0, ready_o}, 32'd1);

        // delayed three-pulse train
        do_start(5, 2, 3, 4, 0);
        cap = '0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cap = {cap[30:0], pulse_o};
            if (i == 11) idx_a = pulse_idx_o;
            if (i == 17) idx_b = pulse_idx_o;
        end
        check("t2_pattern", cap, 32'b00000110000110000110);
        check("t2_idx1", {24'd0, idx_a}, 32'd1);
        check("t2_idx2", {24'd0, idx_b}, 32'd2);
        check("t2_done", {31'd0, done_o}, 32'd1);

        // zero width/spacing, then empty train
        do_start(0, 0, 2, 0, 0);
        cap = '0;
        for (int i = 0; i < 4; i++) begin @(negedge clk); cap = {cap[30:0], pulse_o}; end
        check("t3_pattern", cap, 32'b1010);
        check("t3_done", {31'd0, done_o}, 32'd1);
        do_start(3, 3, 0, 3, 0);
        check("t3_empty_done",  {31'd0, done_o},  32'd1);
        check("t3_empty_ready", {31'd0, ready_o}, 32'd1);
        @(negedge clk);
        check("t3_empty_done_clr", {31'd0, done_o}, 32'd0);
        repeat (4) @(negedge clk);

        // abort during second pulse, start in the same cycle
        do_start(0, 3, 4, 2, 0);
        for (int i = 0; i < 6; i++) @(negedge clk);
        check("t4_on2",  {31'd0, pulse_o}, 32'd1);
        check("t4_idx1", {24'd0, pulse_idx_o}, 32'd1);
        abort_i = 1'b1; start_i = 1'b1; num_pulses_i = 8'd1; delay_i = 16'd0;
        @(negedge clk);
        abort_i = 1'b0; start_i = 1'b0;
        check("t4_abort_pulse", {31'd0, pulse_o}, 32'd0);
        check("t4_abort_ready", {31'd0, ready_o}, 32'd1);
        cnt_on = 0; cnt_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cnt_on += int'(pulse_o); cnt_done += int'(done_o);
        end
        check("t4_no_pulse", cnt_on, 32'd0);
        check("t4_no_done",  cnt_done, 32'd0);
        // abort beats start while idle
        abort_i = 1'b1; start_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0; start_i = 1'b0;
        @(negedge clk);
        check("t4_idle_abort_ready", {31'd0, ready_o}, 32'd1);

        // start while busy ignored, reset mid-delay
        do_start(20, 2, 2, 2, 0);
        repeat (2) @(negedge clk);
        delay_i = 16'd0; num_pulses_i = 8'd1; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("t5_busy_ready", {31'd0, ready_o}, 32'd0);
        @(negedge clk);
        check("t5_busy_nopulse", {31'd0, pulse_o}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_rst_pulse_n", {31'd0, pulse_n}, 32'd1);
        check("t5_rst_ready",   {31'd0, ready_o}, 32'd1);
        cnt_on = 0;
        for (int i = 0; i < 30; i++) begin @(negedge clk); cnt_on += int'(pulse_o); end
        check("t5_no_pulse", cnt_on, 32'd0);

        // width sweep (or constant width when sweep is off)
        do_start(0, 250, 4, 1, 3);
        npulse = 0; run = 0; seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            @(negedge clk);
            if (pulse_o) run++;
            else if (run != 0) begin
                if (npulse < 8) wd[npulse] = run;
                npulse++; run = 0;
            end
            if (done_o) seen = 1'b1;
        end
        check("t6_done_seen", {31'd0, seen}, 32'd1);
        check("t6_npulse", npulse, 32'd4);
`ifdef GLITCH_PULSER_SWEEP_EN
        check("t6_w0", wd[0], 32'd250);
        check("t6_w1", wd[1], 32'd253);
        check("t6_w2", wd[2], 32'd255);
        check("t6_w3", wd[3], 32'd255);
`else
        check("t6_w0", wd[0], 32'd250);
        check("t6_w1", wd[1], 32'd250);
        check("t6_w2", wd[2], 32'd250);
        check("t6_w3", wd[3], 32'd250);
`endif

        // maximum pulse count
        do_start(0, 1, 255, 1, 0);
        npulse = 0; seen = 1'b0; prev = 1'b0;
        for (int i = 0; i < 1000 && !seen; i++) begin
            @(negedge clk);
            if (pulse_o && !prev) npulse++;
            prev = pulse_o;
            if (done_o) seen = 1'b1;
        end
        check("t7_done_seen", {31'd0, seen}, 32'd1);
        check("t7_npulse", npulse, 32'd255);
        check("t7_last_idx", {24'd0, pulse_idx_o}, 32'd254);

        repeat (3) @(negedge clk);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
